// File: rtl/cla_arb_pkg.sv
// Shared types and sizing helpers for the CLA adder arbiter/scheduler.
package cla_arb_pkg;

  // Tag index field is sized for the largest supported requester count (16).
  localparam int TAG_IDX_W = 4;
  // Outstanding-op counter width; holds MAX_OUT up to 255.
  localparam int CNT_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/cla_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester after ptr, wrapping.
module cla_arb_rr_pick
  import cla_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int   pos;
  logic hit;

  // Scan N positions starting one past the pointer; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    hit   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos        = (int'(ptr) + k) % N;
      hit        = eligible[pos] & ~any;
      grant[pos] = hit;
      idx        = hit ? IW'(pos) : idx;
      any        = any | hit;
    end
  end

endmodule

// File: rtl/cla_arb_scheduler.sv
// Shares one fixed-latency pipelined adder among N requesters with round-robin issue.
// Optional macro CLA_ARB_PERF_EN adds per-requester free-running grant counters.
module cla_arb_scheduler
  import cla_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 128,
  parameter int LAT     = 5,
  parameter int MAX_OUT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_op1,
  input  logic [N*W-1:0] req_op2,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_res,
  output logic [W-1:0]   adder_op1,
  output logic [W-1:0]   adder_op2,
  output logic           adder_valid,
  input  logic [W-1:0]   adder_res,
  input  logic           adder_res_valid,
`ifdef CLA_ARB_PERF_EN
  output logic [N*32-1:0] grant_cnt,
`endif
  output logic           err_sync
);

  localparam int               IW      = idx_w(N);
  localparam logic [IW-1:0]    PTR_RST = IW'(N - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    issue_idx;
  logic [N-1:0]     eligible;
  logic [N-1:0]     grant;
  logic             grant_any;
  logic             handshake;
  logic [CNT_W-1:0] out_cnt [N];
  tag_t             tag_line [LAT];
  tag_t             tag_out;

  // A response retiring this cycle frees its slot at once, so a full requester regains grant immediately.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = req_valid[i] & ((out_cnt[i] < MAX_CNT) | rsp_valid[i]);
    end
  end

  cla_arb_rr_pick #(.N(N), .IW(IW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .idx      (grant_idx),
    .any      (grant_any)
  );

  // Grant is suppressed while reset is held.
  always_comb begin
    if (rst) begin
      req_ready = '0;
    end else begin
      req_ready = grant;
    end
  end

  assign handshake = grant_any & ~rst;
  assign tag_out   = tag_line[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= PTR_RST;
      adder_valid <= 1'b0;
      adder_op1   <= '0;
      adder_op2   <= '0;
      issue_idx   <= '0;
    end else begin
      adder_valid <= handshake;
      if (handshake) begin
        ptr       <= grant_idx;
        adder_op1 <= req_op1[int'(grant_idx)*W +: W];
        adder_op2 <= req_op2[int'(grant_idx)*W +: W];
        issue_idx <= grant_idx;
      end
    end
  end

  // The issue register is the first delay stage, so LAT more stages align with adder_res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) tag_line[k] <= '0;
    end else begin
      tag_line[0] <= {adder_valid, TAG_IDX_W'(issue_idx)};
      for (int k = 1; k < LAT; k++) tag_line[k] <= tag_line[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_res   <= '0;
      err_sync  <= 1'b0;
    end else begin
      if (tag_out.valid) begin
        rsp_valid <= ONE_N << tag_out.idx;
        rsp_res   <= adder_res;
      end else begin
        rsp_valid <= '0;
      end
      if (tag_out.valid != adder_res_valid) err_sync <= 1'b1;
    end
  end

  // Outstanding ops per requester; eligibility masking keeps it within 0..MAX_OUT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        out_cnt[i] <= '0;
      end else begin
        case ({grant[i], rsp_valid[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + CNT_ONE;
          2'b01:   out_cnt[i] <= out_cnt[i] - CNT_ONE;
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

`ifdef CLA_ARB_PERF_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        grant_cnt[i*32 +: 32] <= 32'd0;
      end else begin
        grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + {31'd0, grant[i]};
      end
    end
  end
`endif

endmodule

// File: tb/tb_cla_arb_scheduler.sv
// Scoreboard bench for cla_arb_scheduler paired with a behavioural LAT-cycle adder.
module tb_cla_arb_scheduler;

  localparam int N       = 4;
  localparam int W       = 128;
  localparam int LAT     = 5;
  localparam int MAX_OUT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op1;
  logic [N*W-1:0] req_op2;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_res;
  logic [W-1:0]   adder_op1;
  logic [W-1:0]   adder_op2;
  logic           adder_valid;
  logic [W-1:0]   adder_res;
  logic           adder_res_valid;
  logic           err_sync;
`ifdef CLA_ARB_PERF_EN
  logic [N*32-1:0] grant_cnt;
`endif

  cla_arb_scheduler #(.N(N), .W(W), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op1         (req_op1),
    .req_op2         (req_op2),
    .rsp_valid       (rsp_valid),
    .rsp_res         (rsp_res),
    .adder_op1       (adder_op1),
    .adder_op2       (adder_op2),
    .adder_valid     (adder_valid),
    .adder_res       (adder_res),
    .adder_res_valid (adder_res_valid),
`ifdef CLA_ARB_PERF_EN
    .grant_cnt       (grant_cnt),
`endif
    .err_sync        (err_sync)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural adder: LAT-stage pipeline, W-bit sum (carry dropped), one valid can be masked.
  logic [LAT-1:0] mv;
  logic [W-1:0]   md [LAT];
  logic           drop_arm = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mv <= '0;
      for (int k = 0; k < LAT; k++) md[k] <= '0;
    end else begin
      mv    <= {mv[LAT-2:0], adder_valid};
      md[0] <= adder_op1 + adder_op2;
      for (int k = 1; k < LAT; k++) md[k] <= md[k-1];
    end
  end

  assign adder_res_valid = mv[LAT-1] & ~drop_arm;
  assign adder_res       = md[LAT-1];

  typedef struct {
    int           due;
    int           idx;
    logic [W-1:0] res;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  // Monitor: enqueue expected result on each handshake, compare whenever a response appears.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_e.due = cyc + LAT + 2;
          mon_e.idx = i;
          mon_e.res = req_op1[i*W +: W] + req_op2[i*W +: W];
          sb.push_back(mon_e);
        end
      end
    end
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected @cyc %0d: rsp_valid=%b, expected no response", cyc, rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid", W'(rsp_valid), W'(oh(mon_e.idx)));
        check("rsp_res", rsp_res, mon_e.res);
        check("rsp_cycle", W'(cyc), W'(mon_e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op1[i*W +: W] = a;
    req_op2[i*W +: W] = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, W'(req_ready), W'(0));
    check({tag, "_rsp_valid"}, W'(rsp_valid), W'(0));
    check({tag, "_rsp_res"}, rsp_res, '0);
    check({tag, "_adder_valid"}, W'(adder_valid), W'(0));
    check({tag, "_adder_op1"}, adder_op1, '0);
    check({tag, "_adder_op2"}, adder_op2, '0);
    check({tag, "_err_sync"}, W'(err_sync), W'(0));
  endtask

  initial begin
    logic [W-1:0] ones;
    ones      = '1;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;

    // Reset state, with all requesters asserting so that grant gating is visible.
    req_valid = 4'b1111;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst       = 1'b0;
    req_valid = '0;

    // Single op from requester 0 at cycle 10.
    while (cyc < 10) tick();
    req_valid = 4'b0001;
    set_op(0, 128'd3, 128'd4);
    @(negedge clk);
    check("t1_ready", W'(req_ready), W'(4'b0001));
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_adder_valid", W'(adder_valid), W'(1));
    check("t1_adder_op1", adder_op1, 128'd3);
    check("t1_adder_op2", adder_op2, 128'd4);
    repeat (5) tick();
    @(negedge clk);
    check("t1_rsp_early", W'(rsp_valid), W'(0));
    tick();
    @(negedge clk);
    check("t1_rsp_valid", W'(rsp_valid), W'(4'b0001));
    check("t1_rsp_res", rsp_res, 128'd7);
    repeat (4) tick();

    // All four requesting continuously: strict rotation starting after last grant (0).
    for (int k = 0; k < 12; k++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_op(i, W'(k * 16 + i), W'(1000 + i * 7));
      @(negedge clk);
      check("t2_rotation", W'(req_ready), W'(oh((k + 1) % N)));
      tick();
    end
    req_valid = '0;
    repeat (12) tick();

    // Requester 2 alone with MAX_OUT=2: blocked after two grants until the first response.
    req_valid = 4'b0100;
    for (int k = 0; k < 11; k++) begin
      set_op(2, W'(500 + k), W'(k * 3));
      @(negedge clk);
      if (k == 0 || k == 1 || k == 7 || k == 8)
        check("t3_ready", W'(req_ready), W'(4'b0100));
      else
        check("t3_blocked", W'(req_ready), W'(0));
      tick();
    end
    req_valid = '0;
    repeat (12) tick();

    // Carry-out is dropped: all-ones + 1 wraps to zero.
    req_valid = 4'b0010;
    set_op(1, ones, 128'd1);
    @(negedge clk);
    check("t4_ready", W'(req_ready), W'(4'b0010));
    tick();
    req_valid = '0;
    repeat (7) tick();
    @(negedge clk);
    check("t4_rsp_res_zero", rsp_res, '0);
    check("t4_err_clear", W'(err_sync), W'(0));
    repeat (3) tick();

    // Dropped adder strobe sets the sticky sync error one cycle after the tag emerges.
    drop_arm  = 1'b1;
    req_valid = 4'b1000;
    set_op(3, 128'd5, 128'd6);
    @(negedge clk);
    check("t5_ready", W'(req_ready), W'(4'b1000));
    tick();
    req_valid = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("t5_err_sync", W'(err_sync), W'(k >= 7 ? 1 : 0));
      tick();
      if (k == 7) drop_arm = 1'b0;
    end

    // Reset with five ops in flight: everything cleared, no stale responses.
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_op(i, W'(2000 + k * 10 + i), W'(i));
      tick();
    end
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    sb.delete();
    @(negedge clk);
    check_all_zero("t6_reset");
    tick();
    rst = 1'b0;
    repeat (12) tick();
    req_valid = 4'b1111;
    set_op(0, 128'd40, 128'd2);
    @(negedge clk);
    check("t6_ptr_reset_grant", W'(req_ready), W'(4'b0001));
    tick();
    req_valid = '0;
    repeat (10) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
